// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Hazard and stall controller for the 5-stage MIPS32 pipeline. It detects
// these conditions:
//   - load-use hazards between EX and ID,
//   - taken branches resolved in MEM,
//   - jumps decoded in ID,
//   - multi-cycle data-memory waits.
// It then drives the pipeline enables, the flush and the freeze controls.
//
// Handshake / timing contract:
//   - All control outputs (ex_stall, pc_write, if_id_write, if_id_flush,
//     pipe_freeze) are Mealy. They are a pure function of the current state
//     and the current inputs, so they act in the same cycle the condition is
//     seen.
//   - mem_ready qualifies mem_req. A cycle with mem_req=1 and mem_ready=0 is
//     a wait cycle. A cycle with both high completes the access.
//   - mem_timeout and stall_count are registered. They change on the clk
//     edge that ends the cycle being accounted for.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   if_id_rs/rt       source specifiers of the instruction in ID
//   if_id_uses_rt     ID instruction actually reads rt
//   id_ex_mem_read    instruction in EX is a load
//   id_ex_rt          load destination in EX
//   jump              nonzero when ID holds a jump
//   branch_taken      branch resolved taken in MEM
//   mem_req/ready     data-memory access request / completion
//   ex_stall          bubble request to the ID control mux
//   pc_write          PC enable
//   if_id_write       IF/ID enable
//   if_id_flush       clear IF/ID to NOP
//   pipe_freeze       hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout       sticky memory-wait abort flag
//   stall_count       saturating count of cycles with pc_write=0
//   dbg_state         FSM state (0=RUN, 1=MEM_WAIT, 2=BR_FLUSH) for checkers
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  if_id_uses_rt,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [1:0]            jump,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  ex_stall,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  pipe_freeze,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST    = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       timeout_set;
  logic       apply_run;
  logic       skip_mem;
  logic       load_use;
  logic       mem_wait;

  // A load into $zero never produces a value worth waiting for.
  assign load_use = id_ex_mem_read && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) ||
                     (if_id_uses_rt && (id_ex_rt == if_id_rt)));
  assign mem_wait = mem_req && !mem_ready;

  assign dbg_state = state;

  always_comb begin
    ex_stall      = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    pipe_freeze   = 1'b0;
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    wait_cnt_nxt  = wait_cnt;
    timeout_set   = 1'b0;
    apply_run     = 1'b0;
    skip_mem      = 1'b0;

    case (state)
      RUN: apply_run = 1'b1;

      MEM_WAIT: begin
        if (mem_wait && (wait_cnt != WAIT_LAST)) begin
          pipe_freeze  = 1'b1;
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end else begin
          // Either the access completed or the wait budget is exhausted.
          // In both cases the freeze is released this cycle, and the other
          // hazard inputs get normal RUN treatment. On timeout mem_req is
          // still high, so it must not re-arm the freeze in the same cycle.
          timeout_set  = mem_wait;
          skip_mem     = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = RUN;
          apply_run    = 1'b1;
        end
      end

      BR_FLUSH: begin
        if (mem_wait && (wait_cnt != WAIT_LAST)) begin
          // Freeze overrides the flush. flush_cnt holds so the flush window
          // resumes intact once memory answers.
          pipe_freeze  = 1'b1;
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end else begin
          timeout_set  = mem_wait;
          wait_cnt_nxt = '0;
          if_id_flush  = 1'b1;
          ex_stall     = 1'b1;
          if (branch_taken) begin
            flush_cnt_nxt = FLUSH_RELOAD;
          end else if (flush_cnt <= 3'd1) begin
            flush_cnt_nxt = '0;
            state_nxt     = RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - 3'd1;
          end
        end
      end

      default: state_nxt = RUN;
    endcase

    if (apply_run) begin
      if (mem_wait && !skip_mem) begin
        pipe_freeze  = 1'b1;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        state_nxt    = MEM_WAIT;
        wait_cnt_nxt = 8'd1;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        ex_stall    = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt     = BR_FLUSH;
          flush_cnt_nxt = FLUSH_RELOAD;
        end
      end else if (jump != 2'd0) begin
        if_id_flush = 1'b1;
      end else if (load_use) begin
        // The stalled load moves on next cycle and leaves a bubble in EX,
        // so the hazard clears by itself after one cycle.
        ex_stall    = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end
    end

    // Reset forces the default outputs in the reset cycle itself.
    if (rst) begin
      ex_stall    = 1'b0;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      pipe_freeze = 1'b0;
      timeout_set = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
      if (!pc_write && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed bench with two instances that share all inputs:
//   u_a : FLUSH_CYCLES=3, MEM_TIMEOUT=64 (load-use, branch window, mem wait)
//   u_b : FLUSH_CYCLES=1, MEM_TIMEOUT=4  (single-cycle flush, timeout)
//
// Control outputs are packed for comparison as
//   {ex_stall, pc_write, if_id_write, if_id_flush, pipe_freeze}.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

  localparam logic [4:0] C_DEF = 5'b01100;
  localparam logic [4:0] C_LU  = 5'b10000;
  localparam logic [4:0] C_FL  = 5'b11110;
  localparam logic [4:0] C_JMP = 5'b01110;
  localparam logic [4:0] C_FRZ = 5'b00001;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared inputs
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic       if_id_uses_rt, id_ex_mem_read, branch_taken, mem_req, mem_ready;
  logic [1:0] jump;

  // instance outputs
  logic        a_ex_stall, a_pc_write, a_if_id_write, a_if_id_flush, a_pipe_freeze, a_mem_timeout;
  logic [31:0] a_stall_count;
  logic [1:0]  a_state;
  logic        b_ex_stall, b_pc_write, b_if_id_write, b_if_id_flush, b_pipe_freeze, b_mem_timeout;
  logic [31:0] b_stall_count;
  logic [1:0]  b_state;

  hazard_stall_unit #(.REG_ADDR_W(5), .FLUSH_CYCLES(3), .MEM_TIMEOUT(64), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .jump(jump),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .ex_stall(a_ex_stall), .pc_write(a_pc_write), .if_id_write(a_if_id_write),
    .if_id_flush(a_if_id_flush), .pipe_freeze(a_pipe_freeze),
    .mem_timeout(a_mem_timeout), .stall_count(a_stall_count), .dbg_state(a_state)
  );

  hazard_stall_unit #(.REG_ADDR_W(5), .FLUSH_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .jump(jump),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .ex_stall(b_ex_stall), .pc_write(b_pc_write), .if_id_write(b_if_id_write),
    .if_id_flush(b_if_id_flush), .pipe_freeze(b_pipe_freeze),
    .mem_timeout(b_mem_timeout), .stall_count(b_stall_count), .dbg_state(b_state)
  );

  wire [4:0] a_ctrl = {a_ex_stall, a_pc_write, a_if_id_write, a_if_id_flush, a_pipe_freeze};
  wire [4:0] b_ctrl = {b_ex_stall, b_pc_write, b_if_id_write, b_if_id_flush, b_pipe_freeze};

  int total = 0;
  int bad   = 0;

  // driver tasks
  task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] ert, input logic [1:0] jmp,
                       input logic br, input logic req, input logic rdy);
    if_id_rs = rs; if_id_rt = rt; if_id_uses_rt = uses;
    id_ex_mem_read = mr; id_ex_rt = ert; jump = jmp;
    branch_taken = br; mem_req = req; mem_ready = rdy;
    #1;  // let the Mealy outputs settle before checks
  endtask

  task automatic idle();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance past the next rising edge; checks then happen mid-cycle.
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset holds defaults even with active inputs
    apply(5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 2'd1, 1'b1, 1'b1, 1'b0);
    chk("rst_ctrl_a", 32'(a_ctrl), 32'(C_DEF));
    chk("rst_ctrl_b", 32'(b_ctrl), 32'(C_DEF));
    clk_step();
    rst = 1'b0;
    idle();
    chk("rst_count_a", a_stall_count, 32'd0);
    chk("rst_timeout_a", 32'(a_mem_timeout), 32'd0);
    chk("rst_state_a", 32'(a_state), 32'd0);
    chk("idle_ctrl_a", 32'(a_ctrl), 32'(C_DEF));

    // load-use on rs
    apply(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_rs_ctrl", 32'(a_ctrl), 32'(C_LU));
    clk_step();
    idle();
    chk("lu_after_ctrl", 32'(a_ctrl), 32'(C_DEF));
    chk("lu_count_a", a_stall_count, 32'd1);
    chk("lu_count_b", b_stall_count, 32'd1);

    // rt gating
    apply(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("rt_unused_ctrl", 32'(a_ctrl), 32'(C_DEF));
    apply(5'd0, 5'd9, 1'b1, 1'b1, 5'd9, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("rt_used_ctrl", 32'(a_ctrl), 32'(C_LU));
    clk_step();
    // load into $zero never stalls, even when both specifiers are zero
    apply(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("zero_ctrl", 32'(a_ctrl), 32'(C_DEF));
    clk_step();
    idle();
    chk("rt_count_a", a_stall_count, 32'd2);

    // jump
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    chk("jump_ctrl", 32'(a_ctrl), 32'(C_JMP));
    clk_step();
    idle();

    // branch: three-cycle window on u_a, single cycle on u_b
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("br_c1_a", 32'(a_ctrl), 32'(C_FL));
    chk("br_c1_b", 32'(b_ctrl), 32'(C_FL));
    clk_step();
    idle();
    chk("br_c2_a", 32'(a_ctrl), 32'(C_FL));
    chk("br_c2_state_a", 32'(a_state), 32'd2);
    chk("br_c2_b", 32'(b_ctrl), 32'(C_DEF));
    clk_step();
    chk("br_c3_a", 32'(a_ctrl), 32'(C_FL));
    clk_step();
    chk("br_end_a", 32'(a_ctrl), 32'(C_DEF));
    chk("br_end_state_a", 32'(a_state), 32'd0);
    chk("br_count_a", a_stall_count, 32'd2);

    // priority: branch beats jump and load-use
    apply(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 2'd1, 1'b1, 1'b0, 1'b0);
    chk("prio_ctrl_a", 32'(a_ctrl), 32'(C_FL));
    chk("prio_ctrl_b", 32'(b_ctrl), 32'(C_FL));
    clk_step();
    idle();
    clk_step();
    clk_step();
    chk("prio_done_a", 32'(a_ctrl), 32'(C_DEF));

    // memory wait: five frozen cycles, release on the ready cycle
    do_reset();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mw_frz%0d_a", i), 32'(a_ctrl), 32'(C_FRZ));
      clk_step();
    end
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    chk("mw_rel_a", 32'(a_ctrl), 32'(C_DEF));
    clk_step();
    idle();
    chk("mw_count_a", a_stall_count, 32'd5);
    chk("mw_timeout_a", 32'(a_mem_timeout), 32'd0);
    chk("mw_state_a", 32'(a_state), 32'd0);

    // timeout on u_b (MEM_TIMEOUT=4)
    do_reset();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("to_frz%0d_b", i), 32'(b_ctrl), 32'(C_FRZ));
      clk_step();
    end
    chk("to_rel_b", 32'(b_ctrl), 32'(C_DEF));
    chk("to_pre_flag_b", 32'(b_mem_timeout), 32'd0);
    clk_step();
    idle();
    chk("to_flag_b", 32'(b_mem_timeout), 32'd1);
    chk("to_count_b", b_stall_count, 32'd3);
    clk_step();
    clk_step();
    chk("to_sticky_b", 32'(b_mem_timeout), 32'd1);
    chk("to_flag_a", 32'(a_mem_timeout), 32'd0);

    // reset in the middle of a memory wait
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    clk_step();
    clk_step();
    chk("rmw_state_a", 32'(a_state), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmw_rst_ctrl_a", 32'(a_ctrl), 32'(C_DEF));
    clk_step();
    rst = 1'b0;
    idle();
    chk("rmw_ctrl_a", 32'(a_ctrl), 32'(C_DEF));
    chk("rmw_count_a", a_stall_count, 32'd0);
    chk("rmw_state_a2", 32'(a_state), 32'd0);
    chk("rmw_timeout_b", 32'(b_mem_timeout), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Pipeline hazard and stall controller for the 5-stage MIPS32 core. It is the producer of the ex_stall bubble request consumed by the ID-stage control mux. It also drives the PC and IF/ID write enables, the IF/ID flush and the back-end freeze.
- Detects load-use hazards, taken branches, jumps and multi-cycle data-memory waits.
- Sequences the resulting stall and flush windows with a small FSM.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
REG_ADDR_W, 5, register specifier width
FLUSH_CYCLES, 1, consecutive cycles of IF/ID+ID/EX flush per taken branch (1..7)
MEM_TIMEOUT, 64, max consecutive freeze cycles before timeout abort (2..255)
CNT_W, 32, stall counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
if_id_rs  in  REG_ADDR_W  rs of instruction in ID
if_id_rt  in  REG_ADDR_W  rt of instruction in ID
if_id_uses_rt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rt  in  REG_ADDR_W  load destination in EX
jump  in  2  ID jump code; nonzero = jump (j/jal/jr)
branch_taken  in  1  branch resolved taken in MEM
mem_req  in  1  MEM stage has an active data-memory access
mem_ready  in  1  data memory completes access this cycle
ex_stall  out  1  bubble request to ID control mux (zero ID/EX controls)
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  clear IF/ID to NOP
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
mem_timeout  out  1  sticky: memory wait aborted
stall_count  out  CNT_W  cycles with pc_write=0, saturating

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high. All state updates on clk rising edge.
- Reset values (whenever rst=1, regardless of other inputs):
  - state=RUN, flush_cnt=0, wait_cnt=0, mem_timeout=0, stall_count=0.
  - ex_stall=0, pc_write=1, if_id_write=1, if_id_flush=0, pipe_freeze=0.
- Control outputs are Mealy: combinational from state plus inputs, zero-cycle latency.
- mem_timeout and stall_count are registered.
- load_use = id_ex_mem_read & (id_ex_rt!=0) & ((id_ex_rt==if_id_rs) | (if_id_uses_rt & id_ex_rt==if_id_rt)).
- mem_wait = mem_req & ~mem_ready.
- Default outputs are the reset values.
- Priority within a cycle: mem_wait > branch flush > jump > load_use.
- State RUN:
  - mem_wait: pipe_freeze=1, pc_write=0, if_id_write=0, ex_stall=0; next MEM_WAIT; wait_cnt<=1.
  - else branch_taken: if_id_flush=1, ex_stall=1, pc_write=1. If FLUSH_CYCLES>1, next BR_FLUSH with flush_cnt<=FLUSH_CYCLES-1; else stay RUN.
  - else jump!=0: if_id_flush=1, stay RUN.
  - else load_use: ex_stall=1, pc_write=0, if_id_write=0. Exactly one bubble per hazard; stay RUN.
- State MEM_WAIT:
  - Freeze outputs as above while mem_ready=0.
  - Each frozen cycle: wait_cnt<=wait_cnt+1.
  - mem_ready=1: release freeze in that same cycle, then apply RUN rules to the other inputs; next RUN; wait_cnt<=0.
  - Timeout: mem_ready=0 and wait_cnt==MEM_TIMEOUT-1. Release freeze this cycle, mem_timeout<=1 (sticky until rst), next RUN.
  - branch_taken, jump and load_use are ignored while frozen.
- State BR_FLUSH:
  - if_id_flush=1, ex_stall=1, pc_write=1; flush_cnt decrements.
  - flush_cnt==1 on entry to the cycle: next RUN.
  - New branch_taken restarts flush_cnt<=FLUSH_CYCLES-1.
  - mem_wait in BR_FLUSH: freeze outputs override the flush outputs; flush_cnt holds; wait_cnt and timeout as in MEM_WAIT; state stays BR_FLUSH.
- stall_count: +1 on every non-reset cycle with pc_write=0; holds at all-ones.
- Reset mid-MEM_WAIT or mid-BR_FLUSH: immediate return to RUN with reset outputs in the rst cycle.
- $zero rule: a load to $zero never causes a stall.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8 -> one cycle ex_stall=1, pc_write=0, if_id_write=0; next cycle (id_ex_mem_read=0) all default; stall_count=1.
- rt gating: id_ex_rt=9, if_id_rt=9, if_id_uses_rt=0 -> no stall. Repeat with if_id_uses_rt=1 -> stall. id_ex_rt=0 -> never a stall.
- Branch with FLUSH_CYCLES=3: branch_taken pulse -> if_id_flush=ex_stall=1 for exactly 3 cycles, pc_write=1 throughout, then RUN.
- Memory wait: mem_req=1, mem_ready=0 for 5 cycles then 1 -> pipe_freeze=1 and pc_write=0 for 5 cycles, released on the ready cycle; stall_count=5; mem_timeout=0.
- Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ready held 0 -> freeze for 3 cycles, released on cycle 4, mem_timeout=1 stays set until rst.
- Priority/reset: branch_taken, jump=1 and load_use together -> branch outputs only. Assert rst during MEM_WAIT -> next cycle pipe_freeze=0, pc_write=1, stall_count=0, mem_timeout=0.
